// File: rtl/ring_osc_trim_pkg.sv
// rtl/ring_osc_trim_pkg.sv - shared types, constants and code-to-trim mapping for the ring oscillator trim sequencer
package ring_osc_trim_pkg;

  localparam int TRIM_CODE_MAX = 26;
  localparam int TRIM_W        = 26;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_MEASURE,
    ST_ADJUST,
    ST_LOCKED,
    ST_FAIL
  } state_t;

  // Primary bits 0..12 fill first, then secondary bits 13..25, so the bus is a plain thermometer of length k.
  function automatic logic [TRIM_W-1:0] code_to_trim(input logic [4:0] code);
    logic [TRIM_W-1:0] t;
    t = '0;
    for (int i = 0; i < TRIM_W; i++) begin
      t[i] = (int'(code) > i);
    end
    return t;
  endfunction

  // Codes above the top of the trim range clamp to the top.
  function automatic logic [4:0] sat_code(input logic [4:0] code);
    return (code > 5'(TRIM_CODE_MAX)) ? 5'(TRIM_CODE_MAX) : code;
  endfunction

endpackage

// File: rtl/ring_osc_edge_sync.sv
// rtl/ring_osc_edge_sync.sv - two-flop synchronizer and rising-edge pulse for the divided oscillator
module ring_osc_edge_sync (
  input  logic clk,
  input  logic resetb,
  input  logic din,
  output logic rise
);

  // sh[0..1] resynchronize the async input; sh[2] is the previous synchronized value for edge detection.
  logic [2:0] sh;

  // Shift the async input through the synchronizer and history flop.
  always_ff @(posedge clk) begin
    if (!resetb) begin
      sh <= '0;
    end else begin
      sh <= {sh[1:0], din};
    end
  end

  assign rise = sh[1] & ~sh[2];

endmodule

// File: rtl/ring_osc_trim_ctrl.sv
// rtl/ring_osc_trim_ctrl.sv - closed-loop trim sequencer for ring_osc2x13; RING_OSC_TRIM_TRACK_EN enables continuous tracking after lock
module ring_osc_trim_ctrl
  import ring_osc_trim_pkg::*;
#(
  parameter int WINDOW_W   = 10,
  parameter int CNT_W      = 12,
  parameter int SETTLE_CYC = 16
) (
  input  logic              clk,
  input  logic              resetb,
  input  logic              enable,
  input  logic [4:0]        manual_code,
  input  logic [CNT_W-1:0]  target,
  input  logic [3:0]        tol,
  input  logic              osc_div,
  output logic              osc_reset,
  output logic [TRIM_W-1:0] trim,
  output logic [4:0]        code,
  output logic [CNT_W-1:0]  meas_count,
  output logic              busy,
  output logic              locked,
  output logic              fail
);

  localparam int SCNT_W = $clog2(SETTLE_CYC + 1);

  state_t                   state;
  logic [SCNT_W-1:0]        scnt;
  logic [WINDOW_W-1:0]      wcnt;
  logic [CNT_W-1:0]         ecnt;
  logic [CNT_W-1:0]         ecnt_inc;
  logic                     rise;
  logic [4:0]               manual_sat;
  logic signed [CNT_W+1:0]  meas_s;
  logic signed [CNT_W+1:0]  hi_s;
  logic signed [CNT_W+1:0]  lo_s;
  logic                     too_fast;
  logic                     too_slow;

  ring_osc_edge_sync u_sync (
    .clk    (clk),
    .resetb (resetb),
    .din    (osc_div),
    .rise   (rise)
  );

  assign manual_sat = sat_code(manual_code);

  // Edge counter saturates so a runaway oscillator cannot wrap into the tolerance band.
  assign ecnt_inc = (rise && (ecnt != {CNT_W{1'b1}})) ? ecnt + 1'b1 : ecnt;

  // Two extra bits keep target-tol from wrapping when tol exceeds target.
  assign meas_s   = signed'({2'b00, meas_count});
  assign hi_s     = signed'({2'b00, target}) + signed'({{(CNT_W-2){1'b0}}, tol});
  assign lo_s     = signed'({2'b00, target}) - signed'({{(CNT_W-2){1'b0}}, tol});
  assign too_fast = (meas_s > hi_s);
  assign too_slow = (meas_s < lo_s);

  // Calibration sequencer: all outputs are registered and change together with the state.
  always_ff @(posedge clk) begin
    if (!resetb) begin
      state      <= ST_IDLE;
      scnt       <= '0;
      wcnt       <= '0;
      ecnt       <= '0;
      code       <= '0;
      trim       <= '0;
      meas_count <= '0;
      busy       <= 1'b0;
      locked     <= 1'b0;
      fail       <= 1'b0;
      osc_reset  <= 1'b1;
    end else begin
      osc_reset <= 1'b0;
      if (!enable) begin
        state  <= ST_IDLE;
        code   <= manual_sat;
        trim   <= code_to_trim(manual_sat);
        busy   <= 1'b0;
        locked <= 1'b0;
        fail   <= 1'b0;
        scnt   <= '0;
        wcnt   <= '0;
        ecnt   <= '0;
      end else begin
        case (state)
          ST_IDLE: begin
            code  <= manual_sat;
            trim  <= code_to_trim(manual_sat);
            scnt  <= '0;
            busy  <= 1'b1;
            state <= ST_SETTLE;
          end
          ST_SETTLE: begin
            if (scnt == SCNT_W'(SETTLE_CYC - 1)) begin
              scnt  <= '0;
              wcnt  <= '0;
              ecnt  <= '0;
              state <= ST_MEASURE;
            end else begin
              scnt <= scnt + 1'b1;
            end
          end
          ST_MEASURE: begin
            ecnt <= ecnt_inc;
            wcnt <= wcnt + 1'b1;
            if (wcnt == {WINDOW_W{1'b1}}) begin
              meas_count <= ecnt_inc;
              state      <= ST_ADJUST;
            end
          end
          ST_ADJUST: begin
            if (too_fast || too_slow) begin
              locked <= 1'b0;
              if ((too_fast && code == 5'(TRIM_CODE_MAX)) || (too_slow && code == 5'd0)) begin
                fail  <= 1'b1;
                busy  <= 1'b0;
                state <= ST_FAIL;
              end else begin
                code  <= too_fast ? code + 5'd1 : code - 5'd1;
                trim  <= code_to_trim(too_fast ? code + 5'd1 : code - 5'd1);
                scnt  <= '0;
                state <= ST_SETTLE;
              end
            end else begin
              locked <= 1'b1;
              busy   <= 1'b0;
              state  <= ST_LOCKED;
            end
          end
          ST_LOCKED: begin
`ifdef RING_OSC_TRIM_TRACK_EN
            wcnt  <= '0;
            ecnt  <= '0;
            busy  <= 1'b1;
            state <= ST_MEASURE;
`else
            state <= ST_LOCKED;
`endif
          end
          ST_FAIL: begin
            state <= ST_FAIL;
          end
          default: begin
            state <= ST_IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ring_osc_trim_ctrl.sv
// tb/tb_ring_osc_trim_ctrl.sv - self-checking bench for ring_osc_trim_ctrl with a behavioural oscillator
module tb_ring_osc_trim_ctrl;

  logic        clk;
  logic        resetb;
  logic        enable;
  logic [4:0]  manual_code;
  logic [11:0] target;
  logic [3:0]  tol;
  logic        osc_div;
  logic        osc_reset;
  logic [25:0] trim;
  logic [4:0]  code;
  logic [11:0] meas_count;
  logic        busy;
  logic        locked;
  logic        fail;

  ring_osc_trim_ctrl dut (
    .clk         (clk),
    .resetb      (resetb),
    .enable      (enable),
    .manual_code (manual_code),
    .target      (target),
    .tol         (tol),
    .osc_div     (osc_div),
    .osc_reset   (osc_reset),
    .trim        (trim),
    .code        (code),
    .meas_count  (meas_count),
    .busy        (busy),
    .locked      (locked),
    .fail        (fail)
  );

  // clk period is 1000 time units; a 1024-cycle window therefore spans 1024000 units.
  initial clk = 1'b0;
  always #500 clk = ~clk;

  // Oscillator model. Mode 1: rate such that a window sees base - slope*code edges (period grows with code).
  // Mode 2: exact period of 8 clk cycles, aligned to negedge, giving exactly 128 edges in any window.
  int osc_mode = 0;
  int base     = 200;
  int slope    = 10;
  initial osc_div = 1'b0;
  always begin
    if (osc_mode == 1) begin
      int n;
      int h;
      n = base - slope * int'(code);
      if (n <= 0) begin
        osc_div = 1'b0;
        #1000;
      end else begin
        h = 512000 / n;
        osc_div = 1'b1;
        #(h);
        osc_div = 1'b0;
        #(h);
      end
    end else if (osc_mode == 2) begin
      repeat (4) @(negedge clk);
      osc_div = ~osc_div;
    end else begin
      osc_div = 1'b0;
      #1000;
    end
  end

  int n_checks = 0;
  int n_errors = 0;

  typedef struct packed {
    logic [4:0]  code;
    logic [25:0] trim;
    logic        locked;
    logic        fail;
    logic        busy;
  } exp_t;

  exp_t       sbq[$];
  logic [4:0] code_q[$];
  int         chg_cyc[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic push_exp(input logic [4:0] c, input logic [25:0] t, input logic l, input logic f, input logic b);
    exp_t e;
    e.code = c; e.trim = t; e.locked = l; e.fail = f; e.busy = b;
    sbq.push_back(e);
  endtask

  task automatic check_out(input string tag);
    exp_t e;
    chk({tag, ".avail"}, 32'(sbq.size() != 0), 1);
    if (sbq.size() != 0) begin
      e = sbq.pop_front();
      chk({tag, ".code"},   code,   e.code);
      chk({tag, ".trim"},   trim,   e.trim);
      chk({tag, ".locked"}, locked, e.locked);
      chk({tag, ".fail"},   fail,   e.fail);
      chk({tag, ".busy"},   busy,   e.busy);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // kind 0: until locked or fail; kind 1: until code changes; kind 2: until locked drops.
  task automatic run_until(input int budget, input int kind, output bit hit, output int cyc);
    logic [4:0] prev;
    bit         changed;
    prev    = code;
    changed = 1'b0;
    hit     = 1'b0;
    cyc     = 0;
    chg_cyc.delete();
    while (!hit && cyc < budget) begin
      @(posedge clk);
      #1;
      cyc++;
      if (code != prev) begin
        chg_cyc.push_back(cyc);
        changed = 1'b1;
        if (code_q.size() != 0) chk("lock.step_code", code, code_q.pop_front());
        prev = code;
      end
      case (kind)
        0:       hit = locked | fail;
        1:       hit = changed;
        default: hit = !locked;
      endcase
    end
  endtask

  initial begin
    bit          hit;
    int          cyc;
    logic [11:0] saved_meas;

    resetb = 1'b0; enable = 1'b0; manual_code = 5'd0; target = 12'd100; tol = 4'd3;

    // Reset state
    step(3);
    push_exp(5'd0, 26'h0, 1'b0, 1'b0, 1'b0);
    check_out("reset");
    chk("reset.osc_reset", osc_reset, 1);
    chk("reset.meas", meas_count, 0);
    resetb = 1'b1;
    step(1);
    chk("release.osc_reset", osc_reset, 0);
    chk("release.trim", trim, 0);

    // Manual code mapping including saturation
    manual_code = 5'd13; push_exp(5'd13, 26'h0001FFF, 1'b0, 1'b0, 1'b0); step(1); check_out("map13");
    manual_code = 5'd20; push_exp(5'd20, 26'h00FFFFF, 1'b0, 1'b0, 1'b0); step(1); check_out("map20");
    manual_code = 5'd31; push_exp(5'd26, 26'h3FFFFFF, 1'b0, 1'b0, 1'b0); step(1); check_out("map31");
    manual_code = 5'd0;  push_exp(5'd0,  26'h0,       1'b0, 1'b0, 1'b0); step(1); check_out("map0");

    // Lock: count 200-10*code against 100+-3 walks codes 1..10
    osc_mode = 1; base = 200; slope = 10;
    step(20);
    for (int k = 1; k <= 10; k++) code_q.push_back(5'(k));
    push_exp(5'd10, 26'h00003FF, 1'b1, 1'b0, 1'b0);
    enable = 1'b1;
    run_until(15000, 0, hit, cyc);
    chk("lock.timeout", hit, 1);
    check_out("lock");
    chk("lock.steps_left", code_q.size(), 0);
    chk("lock.n_changes", chg_cyc.size(), 10);
    if (chg_cyc.size() >= 2) begin
      chk("lock.first_step_cycle", chg_cyc[0], 1042);
      chk("lock.iter_len", chg_cyc[1] - chg_cyc[0], 1041);
    end
    chk("lock.meas_range", 32'(meas_count >= 12'd97 && meas_count <= 12'd103), 1);
    step(1200);
`ifdef RING_OSC_TRIM_TRACK_EN
    push_exp(5'd10, 26'h00003FF, 1'b1, 1'b0, 1'b1);
`else
    push_exp(5'd10, 26'h00003FF, 1'b1, 1'b0, 1'b0);
`endif
    check_out("lock.hold");
    saved_meas = meas_count;
    enable = 1'b0;
    push_exp(5'd0, 26'h0, 1'b0, 1'b0, 1'b0);
    step(1);
    check_out("lock.exit");
    chk("lock.meas_kept", meas_count, saved_meas);

    // Fail low: too slow already at code 0
    base = 50;
    step(30);
    push_exp(5'd0, 26'h0, 1'b0, 1'b1, 1'b0);
    enable = 1'b1;
    run_until(3000, 0, hit, cyc);
    chk("fail_low.timeout", hit, 1);
    check_out("fail_low");
    chk("fail_low.cycles", cyc, 1042);
    step(50);
    push_exp(5'd0, 26'h0, 1'b0, 1'b1, 1'b0);
    check_out("fail_low.hold");
    enable = 1'b0;
    push_exp(5'd0, 26'h0, 1'b0, 1'b0, 1'b0);
    step(1);
    check_out("fail_low.exit");

    // Abort mid-measure
    base = 200; manual_code = 5'd7;
    step(30);
    enable = 1'b1;
    step(16 + 500);
    chk("abort.busy_mid", busy, 1);
    manual_code = 5'd9; enable = 1'b0;
    push_exp(5'd9, 26'h00001FF, 1'b0, 1'b0, 1'b0);
    step(1);
    check_out("abort");

    // Tolerance edges with an exact 128-edge window
    osc_mode = 2; manual_code = 5'd5; target = 12'd125; tol = 4'd3;
    step(40);
    push_exp(5'd5, 26'h000001F, 1'b1, 1'b0, 1'b0);
    enable = 1'b1;
    run_until(3000, 0, hit, cyc);
    chk("tol_hi.timeout", hit, 1);
    check_out("tol_hi");
    chk("tol_hi.meas", meas_count, 128);
`ifdef RING_OSC_TRIM_TRACK_EN
    tol = 4'd2;
    push_exp(5'd6, 26'h000003F, 1'b0, 1'b0, 1'b1);
    run_until(3000, 2, hit, cyc);
    chk("track.timeout", hit, 1);
    check_out("track.step");
`else
    step(1200);
    push_exp(5'd5, 26'h000001F, 1'b1, 1'b0, 1'b0);
    check_out("terminal");
    chk("terminal.meas", meas_count, 128);
`endif
    enable = 1'b0;
    step(1);
    tol = 4'd3; target = 12'd131;
    push_exp(5'd5, 26'h000001F, 1'b1, 1'b0, 1'b0);
    enable = 1'b1;
    run_until(3000, 0, hit, cyc);
    chk("tol_lo.timeout", hit, 1);
    check_out("tol_lo");
    enable = 1'b0;
    step(1);
    target = 12'd132;
    push_exp(5'd4, 26'h000000F, 1'b0, 1'b0, 1'b1);
    enable = 1'b1;
    run_until(3000, 1, hit, cyc);
    chk("tol_lo_out.timeout", hit, 1);
    check_out("tol_lo_out");
    enable = 1'b0;
    step(2);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/ring_osc_trim_ctrl.md
# ring_osc_trim_ctrl

Closed-loop trim sequencer for the 13-stage, two-trim-bit ring oscillator (`ring_osc2x13`) that feeds the DLL. It counts edges of a divided oscillator output over a fixed window of system clocks and steps a 0..26 trim code until the count is within tolerance of a target. It then drives the oscillator's 26-bit `trim` bus and reports lock or failure.

## Interface
Parameters:
- `WINDOW_W`, 10: measurement window length is 2^WINDOW_W `clk` cycles.
- `CNT_W`, 12: width of the edge counter, `target` and `meas_count`.
- `SETTLE_CYC`, 16: number of `clk` cycles waited after any trim change before measuring.

Ports (one clock, `clk`; reset `resetb` is synchronous and active-low):
- `clk` in 1: system clock.
- `resetb` in 1: synchronous active-low reset.
- `enable` in 1: 1 runs calibration; 0 selects manual mode (IDLE).
- `manual_code` in 5: trim code driven in IDLE and used as the starting code for calibration; values >26 saturate to 26.
- `target` in CNT_W: desired edge count per window.
- `tol` in 4: allowed ± deviation from `target`.
- `osc_div` in 1: divided ring-oscillator output; asynchronous to `clk`.
- `osc_reset` out 1: ring-oscillator reset.
- `trim` out 26: thermometer trim bus to the oscillator.
- `code` out 5: current trim code.
- `meas_count` out CNT_W: last completed window count.
- `busy` out 1: high in SETTLE, MEASURE and ADJUST.
- `locked` out 1: count within tolerance.
- `fail` out 1: required step is past a code bound.

## Operation
- Code→trim mapping, for code k in 0..26:
  - `trim[i]=1` for i < min(k,13) (primary bits first).
  - `trim[13+j]=1` for j < k−13 (secondary bits).
  - All other bits 0.
- `osc_div` passes through a 2-flop synchronizer and a rising-edge detector.
- States:
  - IDLE: `code`=sat(`manual_code`). `enable`=1 → SETTLE.
  - SETTLE: wait SETTLE_CYC cycles, clear the edge counter → MEASURE.
  - MEASURE: count detected edges for 2^WINDOW_W cycles. The counter saturates at 2^CNT_W−1. At window end, latch `meas_count` → ADJUST.
  - ADJUST (1 cycle), comparisons done in CNT_W+2-bit signed arithmetic:
    - `meas_count` > `target`+`tol`: oscillator too fast; `code`+1 → SETTLE.
    - `meas_count` < `target`−`tol`: oscillator too slow; `code`−1 → SETTLE.
    - Otherwise → LOCKED.
    - A step beyond 26 or below 0 goes → FAIL instead, with `code` held.
  - LOCKED: `locked`=1 (behaviour set by the configuration macro below).
  - FAIL: `fail`=1, `code` held.
- Equality at either bound (`meas_count` = `target`±`tol`) counts as within tolerance.
- `enable`=0 in any state → IDLE on the next cycle. This clears `locked`, `fail`, `busy` and the counters; `meas_count` is retained.
- `enable` must drop to leave LOCKED or FAIL.

## Timing
- Reset values: `trim`=0, `code`=0, `meas_count`=0, `busy`=0, `locked`=0, `fail`=0, `osc_reset`=1.
- `osc_reset` deasserts on the first cycle after `resetb` goes high.
- Edge detection latency: 3 `clk` cycles from an `osc_div` rise to the count increment.
- `trim` and `code` are registered and update together, one cycle after ADJUST.
- One iteration takes SETTLE_CYC + 2^WINDOW_W + 1 cycles.
- `locked` and `fail` assert in the cycle after ADJUST.
- Reset asserted mid-operation overrides everything on the next `clk` edge.
- `osc_div` must be slower than `clk`/4 for the count to be exact.

## Configuration
- Macro `RING_OSC_TRIM_TRACK_EN`.
- Defined: LOCKED re-enters MEASURE immediately (no SETTLE) for continuous tracking.
  - `locked` stays 1 while the count remains within tolerance.
  - An out-of-tolerance result drops `locked` and steps the code as in ADJUST.
- Undefined: LOCKED is terminal and no further measurement occurs.

## Structure
- Package `ring_osc_trim_pkg`:
  - state enum.
  - `TRIM_CODE_MAX`=26 and `TRIM_W`=26.
  - `code_to_trim()` function.
- Sub-module `ring_osc_edge_sync`: 2-flop synchronizer plus rising-edge pulse.

## Test plan
Use a behavioural oscillator model whose `osc_div` period grows linearly with `code`.
- Reset: hold `resetb`=0 for 3 cycles → all outputs at their reset values, `osc_reset`=1; after release, `osc_reset`=0 and `trim`=0.
- Lock: `manual_code`=0, model count = 200−10·code, `target`=100, `tol`=3, `enable`=1 → steps through codes 1..10, then `locked`=1, `code`=10, `trim`=26'h00003FF.
- Mapping: `manual_code`=13 → `trim`=26'h0001FFF; `manual_code`=20 → `trim`=26'h00FFFFF; `manual_code`=31 → `code`=26, `trim`=26'h3FFFFFF.
- Fail low: model too slow at code 0 (count 50, `target`=100) → ADJUST yields FAIL, `fail`=1, `code`=0.
- Abort: drop `enable` midway through MEASURE → next cycle `busy`=0, state IDLE, `code`=sat(`manual_code`).
- Tolerance edge: count exactly `target`+`tol` (103) → `locked`=1. With `RING_OSC_TRIM_TRACK_EN`, then changing the model so the count is 104 → `locked`=0 and `code` incremented.
